univ_shift_reg: RTL

//  Parametrised universal shift register for datapath and serial-link use.

---
 rtl/univ_shift_reg_if.sv | 41 ++++
 rtl/univ_shift_reg.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_if.sv
// rtl/univ_shift_reg_if.sv - Command, data and status bundle for univ_shift_reg
//
// Purpose: groups the operation handshake, serial links and register status
// of the universal shift register into one interface.
// Ports (all bundled signals, MSB is bit 0):
//   d[0:WIDTH-1]  parallel load data         op[2:0]    operation code
//   cnt[CNT_W-1:0] multi-cycle shift count   op_valid   op/d/cnt presented
//   abort         stop a running op          sin_left   serial in at q[0]
//   sin_right     serial in at q[WIDTH-1]    q          register contents
//   sout_left     q[0]                       sout_right q[WIDTH-1]
//   ready         idle, accepts an op        busy       multi-cycle op running
//   done          one-cycle completion pulse
// Modports: master drives commands, slave is the shift register.
interface univ_shift_reg_if #(
    parameter int WIDTH = 36,
    parameter int CNT_W = 6
);
    logic [0:WIDTH-1] d;
    logic [2:0]       op;
    logic [CNT_W-1:0] cnt;
    logic             op_valid;
    logic             abort;
    logic             sin_left;
    logic             sin_right;
    logic [0:WIDTH-1] q;
    logic             sout_left;
    logic             sout_right;
    logic             ready;
    logic             busy;
    logic             done;

    modport master (
        output d, op, cnt, op_valid, abort, sin_left, sin_right,
        input  q, sout_left, sout_right, ready, busy, done
    );

    modport slave (
        input  d, op, cnt, op_valid, abort, sin_left, sin_right,
        output q, sout_left, sout_right, ready, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - Universal shift register with multi-cycle shift-by-count
//
// Purpose: parallel load, clear, single-step left/right shift with serial
// fill, and multi-cycle shift/rotate by count sequenced by an IDLE/RUN FSM.
// Bit 0 is the leftmost (MSB) bit; left shifts move bits towards q[0].
// Ports:
//   clk    clock, all state changes on posedge
//   reset  asynchronous active-high reset
//   bus    univ_shift_reg_if.slave (op handshake, serial links, status)
// Optional feature: macro USR_ROTATE_EN enables op 110 (rotate left by cnt);
// when undefined, op 110 behaves as HOLD and no rotate logic exists.
module univ_shift_reg #(
    parameter int WIDTH = 36,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    univ_shift_reg_if.slave   bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL1  = 3'b010;
    localparam logic [2:0] OP_SHR1  = 3'b011;
    localparam logic [2:0] OP_SHLN  = 3'b100;
    localparam logic [2:0] OP_SHRN  = 3'b101;
`ifdef USR_ROTATE_EN
    localparam logic [2:0] OP_ROTLN = 3'b110;
`endif
    localparam logic [2:0] OP_CLEAR = 3'b111;

    localparam logic [1:0] M_SHL = 2'd0;
    localparam logic [1:0] M_SHR = 2'd1;
`ifdef USR_ROTATE_EN
    localparam logic [1:0] M_ROT = 2'd2;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state, state_n;
    logic [0:WIDTH-1] q_r, q_n;
    logic [CNT_W-1:0] remaining, remaining_n;
    logic [1:0]       mode, mode_n;
    logic             done_r, done_n;

    logic [0:WIDTH-1] shl_val;
    logic [0:WIDTH-1] shr_val;

    // Serial inputs are live: each shift edge uses whatever is present then.
    assign shl_val = {q_r[1:WIDTH-1], bus.sin_right};
    assign shr_val = {bus.sin_left, q_r[0:WIDTH-2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            q_r       <= '0;
            remaining <= '0;
            mode      <= M_SHL;
            done_r    <= 1'b0;
        end else begin
            state     <= state_n;
            q_r       <= q_n;
            remaining <= remaining_n;
            mode      <= mode_n;
            done_r    <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        q_n         = q_r;
        remaining_n = remaining;
        mode_n      = mode;
        done_n      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.op_valid) begin
                    case (bus.op)
                        OP_HOLD:  q_n = q_r;
                        OP_LOAD:  q_n = bus.d;
                        OP_SHL1:  q_n = shl_val;
                        OP_SHR1:  q_n = shr_val;
                        OP_CLEAR: q_n = '0;
                        OP_SHLN, OP_SHRN: begin
                            mode_n = (bus.op == OP_SHLN) ? M_SHL : M_SHR;
                            // A zero count completes on the acceptance edge.
                            if (bus.cnt == CNT_ZERO) begin
                                done_n = 1'b1;
                            end else begin
                                state_n     = RUN;
                                remaining_n = bus.cnt;
                            end
                        end
`ifdef USR_ROTATE_EN
                        OP_ROTLN: begin
                            mode_n = M_ROT;
                            if (bus.cnt == CNT_ZERO) begin
                                done_n = 1'b1;
                            end else begin
                                state_n     = RUN;
                                remaining_n = bus.cnt;
                            end
                        end
`endif
                        default: q_n = q_r;
                    endcase
                end
            end
            RUN: begin
                if (bus.abort) begin
                    // Abort freezes q at its current value and skips done.
                    state_n     = IDLE;
                    remaining_n = CNT_ZERO;
                end else begin
                    case (mode)
                        M_SHL:   q_n = shl_val;
                        M_SHR:   q_n = shr_val;
`ifdef USR_ROTATE_EN
                        M_ROT:   q_n = {q_r[1:WIDTH-1], q_r[0]};
`endif
                        default: q_n = q_r;
                    endcase
                    remaining_n = remaining - CNT_ONE;
                    if (remaining == CNT_ONE) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n     = IDLE;
                remaining_n = CNT_ZERO;
            end
        endcase
    end

    assign bus.q          = q_r;
    assign bus.sout_left  = q_r[0];
    assign bus.sout_right = q_r[WIDTH-1];
    assign bus.busy       = (state == RUN);
    assign bus.ready      = (state != RUN);
    assign bus.done       = done_r;
endmodule
